alu_addsub_pipe: RTL and testbench

ALU_ADDSUB_PIPE -- requirements
Module: alu_addsub_pipe

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_addsub_core.sv | 89 ++++++++
 rtl/alu_addsub_pipe.sv | 113 +++++++++++
 tb/tb_alu_addsub_pipe.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared types for the add/sub pipeline:
//   alu_op_e    - 2-bit operation encoding (ADD, SUB, ACC, CLR)
//   alu_flags_t - carry/no-borrow, signed overflow and the three compare flags
// -----------------------------------------------------------------------------
package alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,  // a + b
    OP_SUB = 2'd1,  // a - b
    OP_ACC = 2'd2,  // acc + b, written back to acc
    OP_CLR = 2'd3   // acc := 0
  } alu_op_e;

  typedef struct packed {
    logic c_out;  // carry out of MSB (no-borrow for SUB)
    logic ovf;    // signed overflow of the actual addition
    logic alb;    // a < b
    logic agb;    // a > b
    logic aeb;    // a == b
  } alu_flags_t;

endpackage

// File: rtl/alu_addsub_core.sv
// -----------------------------------------------------------------------------
// alu_addsub_core
// Purely combinational adder/subtractor with magnitude compare.
//   i_op    : operation (alu_op_e)
//   i_a/i_b : operands
//   i_acc   : current accumulator value (first addend for ACC)
//   o_sum   : result
//   o_flags : c_out, ovf, alb, agb, aeb
// Parameters: WIDTH (4..32), SIGNED_CMP (0 = unsigned, 1 = two's-complement).
// Build option: define ALU_SATURATE_EN to clamp overflowing results.
// -----------------------------------------------------------------------------
module alu_addsub_core
  import alu_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int SIGNED_CMP = 0
) (
  input  alu_op_e          i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_acc,
  output logic [WIDTH-1:0] o_sum,
  output alu_flags_t       o_flags
);

  localparam int MSB = WIDTH - 1;

  logic [WIDTH-1:0] w_x;
  logic [WIDTH-1:0] w_y;
  logic             w_cin;
  logic [WIDTH:0]   w_raw;
  logic             w_ovf;
  logic             w_lt;
  logic             w_eq;

  // Operand steering onto one shared adder. CLR leaves both addends at zero,
  // which makes the sum, carry and overflow all zero without special cases.
  // NOTE: every always_comb output gets a default before the case, so no path can infer a latch.
  always_comb begin
    w_x   = '0;
    w_y   = '0;
    w_cin = 1'b0;
    case (i_op)
      OP_ADD: begin
        w_x = i_a;
        w_y = i_b;
      end
      OP_SUB: begin
        w_x   = i_a;
        w_y   = ~i_b;
        w_cin = 1'b1;
      end
      OP_ACC: begin
        w_x = i_acc;
        w_y = i_b;
      end
      default: ;
    endcase
  end

  assign w_raw = {1'b0, w_x} + {1'b0, w_y} + {{WIDTH{1'b0}}, w_cin};
  assign w_ovf = (w_x[MSB] == w_y[MSB]) && (w_raw[MSB] != w_x[MSB]);

`ifdef ALU_SATURATE_EN
  localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  // On overflow both addends share a sign, and that sign picks the rail.
  assign o_sum = w_ovf ? (w_x[MSB] ? SAT_MIN : SAT_MAX) : w_raw[MSB:0];
`else
  assign o_sum = w_raw[MSB:0];
`endif

  // Compare always looks at the raw a/b operands, whatever the operation.
  always_comb begin
    if (SIGNED_CMP != 0) w_lt = $signed(i_a) < $signed(i_b);
    else                 w_lt = i_a < i_b;
  end
  assign w_eq = (i_a == i_b);

  always_comb begin
    o_flags       = '0;
    o_flags.c_out = w_raw[WIDTH];
    o_flags.ovf   = w_ovf;
    o_flags.alb   = w_lt;
    o_flags.agb   = !w_lt && !w_eq;
    o_flags.aeb   = w_eq;
  end

endmodule

// File: rtl/alu_addsub_pipe.sv
// -----------------------------------------------------------------------------
// alu_addsub_pipe
// Two-stage valid/ready add/sub/accumulate pipeline.
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   : operand beat handshake
//   op, a, b            : operation and operands
//   out_valid/out_ready : result beat handshake
//   sum                 : result
//   c_out, ovf          : carry/no-borrow, signed overflow
//   alb, agb, aeb       : a<b, a>b, a==b (SIGNED_CMP selects signedness)
// Stage 1 registers the operands, stage 2 registers the result; a beat
// accepted in cycle n is presented in cycle n+2 when not back-pressured.
// Build option: define ALU_SATURATE_EN to clamp overflowing ADD/SUB/ACC.
// -----------------------------------------------------------------------------
module alu_addsub_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int SIGNED_CMP = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf,
  output logic             alb,
  output logic             agb,
  output logic             aeb
);

  logic             r_s1_valid;
  alu_op_e          r_s1_op;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_sum;
  alu_flags_t       r_flags;
  logic [WIDTH-1:0] r_acc;

  logic             w_advance;
  logic [WIDTH-1:0] w_core_sum;
  alu_flags_t       w_core_flags;

  // Stage 2 can take a new value when it is empty or being drained this cycle;
  // stage 1 can take a beat when it is empty or moving into stage 2.
  assign w_advance = !r_out_valid || out_ready;
  assign in_ready  = w_advance || !r_s1_valid;

  // Stage 1: operand register.
  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_op    <= OP_ADD;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
    end else if (in_ready) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_op <= alu_op_e'(op);
        r_s1_a  <= a;
        r_s1_b  <= b;
      end
    end
  end

  alu_addsub_core #(
    .WIDTH      (WIDTH),
    .SIGNED_CMP (SIGNED_CMP)
  ) u_core (
    .i_op    (r_s1_op),
    .i_a     (r_s1_a),
    .i_b     (r_s1_b),
    .i_acc   (r_acc),
    .o_sum   (w_core_sum),
    .o_flags (w_core_flags)
  );

  // Stage 2: result register and accumulator. The accumulator is written in
  // the same edge that moves an ACC/CLR beat forward, so a following ACC beat
  // sitting in stage 1 one cycle later already sees the updated value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_sum       <= '0;
      r_flags     <= '0;
      r_acc       <= '0;
    end else if (w_advance) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_sum   <= w_core_sum;
        r_flags <= w_core_flags;
        if (r_s1_op == OP_ACC || r_s1_op == OP_CLR) r_acc <= w_core_sum;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign c_out     = r_flags.c_out;
  assign ovf       = r_flags.ovf;
  assign alb       = r_flags.alb;
  assign agb       = r_flags.agb;
  assign aeb       = r_flags.aeb;

endmodule

// File: tb/tb_alu_addsub_pipe.sv
// -----------------------------------------------------------------------------
// tb_alu_addsub_pipe
// Drives an unsigned-compare and a signed-compare instance of alu_addsub_pipe
// (WIDTH=8) from the same stimulus. An arithmetic model predicts each accepted
// beat's result; one process compares every presented result in order.
// Directed tests add literal expectations for latency, flags and corner cases.
// -----------------------------------------------------------------------------
module tb_alu_addsub_pipe;

  typedef struct {
    logic [7:0] sum;
    logic       c;
    logic       v;
    logic       ltu, gtu, equ;
    logic       lts, gts, eqs;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       out_ready;
  logic [1:0] op;
  logic [7:0] a, b;

  logic       in_ready, out_valid, c_out, ovf, alb, agb, aeb;
  logic [7:0] sum;
  logic       in_ready_s, out_valid_s, c_out_s, ovf_s, alb_s, agb_s, aeb_s;
  logic [7:0] sum_s;

  int n_pass    = 0;
  int n_total   = 0;
  int n_retired = 0;

  exp_t       q[$];
  logic [7:0] m_acc = 8'h00;

`ifdef ALU_SATURATE_EN
  localparam logic [7:0] EXP_7F_PLUS_1 = 8'h7F;
`else
  localparam logic [7:0] EXP_7F_PLUS_1 = 8'h80;
`endif

  alu_addsub_pipe #(.WIDTH(8), .SIGNED_CMP(0)) dut_u (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .c_out(c_out), .ovf(ovf), .alb(alb), .agb(agb), .aeb(aeb)
  );

  alu_addsub_pipe #(.WIDTH(8), .SIGNED_CMP(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
    .op(op), .a(a), .b(b), .out_valid(out_valid_s), .out_ready(out_ready),
    .sum(sum_s), .c_out(c_out_s), .ovf(ovf_s), .alb(alb_s), .agb(agb_s), .aeb(aeb_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Result of one beat from plain integer arithmetic.
  function automatic exp_t model(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                                 input logic [7:0] acc_in, output logic [7:0] acc_out);
    exp_t e;
    int   ures;
    int   sres;
    ures = 0;
    sres = 0;
    case (o)
      2'd0: begin ures = int'(x) + int'(y);      sres = int'($signed(x)) + int'($signed(y)); end
      2'd1: begin ures = int'(x) - int'(y);      sres = int'($signed(x)) - int'($signed(y)); end
      2'd2: begin ures = int'(acc_in) + int'(y); sres = int'($signed(acc_in)) + int'($signed(y)); end
      default: ;
    endcase
    e.sum = 8'(ures);
    if (o == 2'd1) e.c = (ures >= 0);
    else           e.c = (ures > 255);
    e.v = (sres > 127) || (sres < -128);
`ifdef ALU_SATURATE_EN
    if (e.v) e.sum = (sres > 127) ? 8'h7F : 8'h80;
`endif
    e.ltu = x < y;
    e.gtu = x > y;
    e.equ = x == y;
    e.lts = $signed(x) < $signed(y);
    e.gts = $signed(x) > $signed(y);
    e.eqs = x == y;
    acc_out = acc_in;
    if (o == 2'd2) acc_out = e.sum;
    if (o == 2'd3) acc_out = 8'h00;
    return e;
  endfunction

  // Scoreboard: compare, then retire, then accept -- all on the falling edge
  // where inputs and outputs are stable for the coming rising edge.
  always @(negedge clk) begin
    exp_t e;
    logic [7:0] nacc;
    if (!rst_n) begin
      q.delete();
      m_acc = 8'h00;
    end else begin
      check("valid_match", 32'(out_valid_s), 32'(out_valid));
      check("ready_match", 32'(in_ready_s), 32'(in_ready));
      if (out_valid) begin
        if (q.size() == 0) begin
          check("unexpected_result", 32'(out_valid), 32'd0);
        end else begin
          e = q[0];
          check("m_sum",   32'(sum),   32'(e.sum));
          check("m_c_out", 32'(c_out), 32'(e.c));
          check("m_ovf",   32'(ovf),   32'(e.v));
          check("m_cmp_u", 32'({alb, agb, aeb}), 32'({e.ltu, e.gtu, e.equ}));
          check("m_sum_s", 32'(sum_s), 32'(e.sum));
          check("m_cmp_s", 32'({alb_s, agb_s, aeb_s}), 32'({e.lts, e.gts, e.eqs}));
        end
        if (out_ready && q.size() > 0) begin
          void'(q.pop_front());
          n_retired++;
        end
      end
      if (in_valid && in_ready) begin
        e = model(op, a, b, m_acc, nacc);
        m_acc = nacc;
        q.push_back(e);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One isolated beat: checks it is not visible one cycle after acceptance
  // and is visible two cycles after; returns on the falling edge it shows.
  task automatic single(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y);
    in_valid = 1'b1; op = o; a = x; b = y;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check("latency_early", 32'(out_valid), 32'd0);
    step();
    @(negedge clk);
    check("latency_valid", 32'(out_valid), 32'd1);
  endtask

  logic [1:0] tv_op [8] = '{2'd1, 2'd1, 2'd1, 2'd3, 2'd2, 2'd2, 2'd0, 2'd2};
  logic [7:0] tv_a  [8] = '{8'h80, 8'h42, 8'h00, 8'h11, 8'h00, 8'hC0, 8'hFF, 8'h05};
  logic [7:0] tv_b  [8] = '{8'h01, 8'h42, 8'h80, 8'h22, 8'h70, 8'h20, 8'hFF, 8'h90};

  initial begin
    int         idx;
    int         cyc;
    int         retired0;
    logic       took;
    logic [7:0] chain [4] = '{8'd0, 8'd3, 8'd7, 8'd12};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; op = 2'd0; a = 8'h00; b = 8'h00;
    #3;
    check("rst_out_valid",   32'(out_valid), 32'd0);
    check("rst_sum",         32'(sum), 32'd0);
    check("rst_flags",       32'({c_out, ovf, alb, agb, aeb}), 32'd0);
    check("rst_out_valid_s", 32'(out_valid_s), 32'd0);
    check("rst_flags_s",     32'({c_out_s, ovf_s, alb_s, agb_s, aeb_s}), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("in_ready_after_rst", 32'(in_ready), 32'd1);

    // ADD 0xF0 + 0x20
    single(2'd0, 8'hF0, 8'h20);
    check("add_sum", 32'(sum), 32'h10);
    check("add_c",   32'(c_out), 32'd1);
    check("add_ovf", 32'(ovf), 32'd0);
    check("add_agb", 32'(agb), 32'd1);
    check("add_alb_signed", 32'(alb_s), 32'd1);
    step();

    // SUB 0x05 - 0x07
    single(2'd1, 8'h05, 8'h07);
    check("sub_sum", 32'(sum), 32'hFE);
    check("sub_c",   32'(c_out), 32'd0);
    check("sub_alb", 32'(alb), 32'd1);
    step();

    // 0x80 vs 0x01: greater unsigned, less signed
    single(2'd0, 8'h80, 8'h01);
    check("cmp80_agb_u", 32'(agb), 32'd1);
    check("cmp80_alb_s", 32'(alb_s), 32'd1);
    check("cmp80_sum",   32'(sum), 32'h81);
    step();

    // ADD 0x7F + 0x01 overflows
    single(2'd0, 8'h7F, 8'h01);
    check("ovf_flag", 32'(ovf), 32'd1);
    check("ovf_sum",  32'(sum), 32'(EXP_7F_PLUS_1));
    step();

    // CLR then ACC 3,4,5 back to back: results on consecutive cycles
    for (int j = 0; j < 6; j++) begin
      if (j == 0)     begin in_valid = 1'b1; op = 2'd3; a = 8'h00; b = 8'h00; end
      else if (j < 4) begin in_valid = 1'b1; op = 2'd2; a = 8'hAA; b = 8'(j + 2); end
      else            in_valid = 1'b0;
      @(negedge clk);
      if (j >= 2) begin
        check("chain_valid", 32'(out_valid), 32'd1);
        check("chain_sum",   32'(sum), 32'(chain[j-2]));
      end
      step();
    end
    repeat (2) step();

    // Backpressure: out_ready low for 5 cycles with input always offered
    out_ready = 1'b0;
    for (int j = 0; j < 8; j++) begin
      in_valid = (j < 6);
      op = 2'd0;
      a  = (j == 0) ? 8'h11 : (j == 1) ? 8'h22 : 8'h33;
      b  = (j == 0) ? 8'h01 : (j == 1) ? 8'h02 : 8'h03;
      if (j == 5) out_ready = 1'b1;
      @(negedge clk);
      if (j >= 2 && j <= 4) begin
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_valid",    32'(out_valid), 32'd1);
        check("bp_hold_sum", 32'(sum), 32'h12);
      end
      if (j == 6) check("bp_drain_b", 32'(sum), 32'h24);
      if (j == 7) check("bp_drain_c", 32'(sum), 32'h36);
      step();
    end
    repeat (2) step();
    check("bp_queue_empty", 32'(q.size()), 32'd0);

    // Mixed table with a stuttering out_ready
    idx = 0;
    cyc = 0;
    while (idx < 8 && cyc < 200) begin
      in_valid = 1'b1; op = tv_op[idx]; a = tv_a[idx]; b = tv_b[idx];
      out_ready = (cyc % 3) != 2;
      @(negedge clk);
      took = in_ready;
      step();
      if (took) idx++;
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("table_issued", 32'(idx), 32'd8);
    repeat (4) step();
    check("table_queue_empty", 32'(q.size()), 32'd0);

    // Reset with two beats in flight
    out_ready = 1'b0;
    in_valid = 1'b1; op = 2'd2; a = 8'h00; b = 8'h05;
    step();
    b = 8'h06;
    step();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_sum",       32'(sum), 32'd0);
    check("midrst_flags",     32'({c_out, ovf, alb, agb, aeb}), 32'd0);
    check("midrst_valid_s",   32'(out_valid_s), 32'd0);
    @(negedge clk);
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    retired0 = n_retired;
    repeat (4) step();
    check("midrst_no_stale", 32'(n_retired - retired0), 32'd0);
    single(2'd2, 8'h09, 8'h01);
    check("midrst_acc_cleared", 32'(sum), 32'h01);
    step();
    repeat (2) step();
    check("final_queue_empty", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "simulation time limit reached");
  end

endmodule
